// File: rtl/rtc_write_arbiter.sv
// -----------------------------------------------------------------------------
// rtc_write_arbiter
//
// Shares the single RTC write engine among N_REQ requesters. Requesters are
// served round-robin; each grant becomes one engine transaction (iniciar held
// high with a stable dir/dato until the engine answers with a completion
// pulse). A watchdog aborts transactions whose completion never arrives, and a
// recovery gap of idle cycles follows every transaction.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   TIMEOUT  maximum RUN cycles waiting for completion before abort (>=1)
//   GAP      idle cycles inserted after each transaction (>=0)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   req        per-requester level request, held until its done/err
//   req_dir    per-requester RTC address, slice i = [8*i+7:8*i]
//   req_dato   per-requester write data, same slicing
//   gnt        one-hot grant, high for the whole transaction
//   done       1-cycle pulse: transaction of requester i completed
//   err        1-cycle pulse: transaction of requester i aborted by timeout
//   iniciar    start/hold strobe to the write engine
//   dir        address to the write engine
//   dato       data to the write engine
//   final_ack  completion pulse from the write engine ("final" is a reserved
//              word in SystemVerilog, so the engine's final signal lands here)
//   busy       high in every state except IDLE
//
// All outputs are registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module rtc_write_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 255,
   parameter int GAP     = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_dir,
   input  logic [8*N_REQ-1:0] req_dato,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic [N_REQ-1:0]   err,
   output logic               iniciar,
   output logic [7:0]         dir,
   output logic [7:0]         dato,
   input  logic               final_ack,
   output logic               busy
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_MAX  = '1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE,
      S_GAP
   } state_t;

   state_t        state;
   logic [PW-1:0] rr_ptr;
   logic [TW-1:0] tmo_cnt;
   logic [GW-1:0] gap_cnt;

   // Per-requester views of the packed address/data buses.
   logic [7:0]       dir_slice  [N_REQ];
   logic [7:0]       dato_slice [N_REQ];
   logic [N_REQ-1:0] win_onehot;

   logic          win_found;
   logic [PW-1:0] win_idx;
   logic [PW-1:0] cand;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign dir_slice[gi]  = req_dir[8*gi +: 8];
      assign dato_slice[gi] = req_dato[8*gi +: 8];
      assign win_onehot[gi] = (win_idx == PW'(gi));
   end

   // Round-robin pick: first set request searching rr_ptr+1, rr_ptr+2, ...
   // The walk runs from the farthest candidate to the nearest so that the
   // nearest requesting one is the last (and therefore winning) assignment.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = PW'((int'(rr_ptr) + k) % N_REQ);
         if (req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         rr_ptr  <= PW'(N_REQ - 1);
         tmo_cnt <= '0;
         gap_cnt <= '0;
         gnt     <= '0;
         done    <= '0;
         err     <= '0;
         iniciar <= 1'b0;
         dir     <= 8'h00;
         dato    <= 8'h00;
         busy    <= 1'b0;
      end else begin
         // done/err are single-cycle pulses.
         done <= '0;
         err  <= '0;
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  gnt     <= win_onehot;
                  dir     <= dir_slice[win_idx];
                  dato    <= dato_slice[win_idx];
                  iniciar <= 1'b1;
                  rr_ptr  <= win_idx;
                  tmo_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= S_RUN;
               end
            end

            S_RUN: begin
               // Completion takes priority over a timeout in the same cycle.
               if (final_ack || (tmo_cnt == TMO_LAST)) begin
                  iniciar <= 1'b0;
                  gnt     <= '0;
                  dir     <= 8'h00;
                  dato    <= 8'h00;
                  if (final_ack) begin
                     done <= gnt;
                  end else begin
                     err <= gnt;
                  end
                  state <= S_DONE;
               end else if (tmo_cnt != TMO_MAX) begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end

            S_DONE: begin
               if (GAP > 0) begin
                  gap_cnt <= GAP_LOAD;
                  state   <= S_GAP;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end

            S_GAP: begin
               // Requests are deliberately not looked at while recovering.
               if (gap_cnt <= GAP_ONE) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rtc_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rtc_write_arbiter
//
// Randomised scoreboard bench for rtc_write_arbiter. Each scenario applies a
// set of requests (some requesters asking more than once); a round-robin
// reference model predicts the order of transactions, their address/data, the
// completion delay the engine model will use and whether each ends in done or
// err. A separate monitor pops those predictions as the DUT runs transactions.
// -----------------------------------------------------------------------------
module tb_rtc_write_arbiter;

   localparam int N    = 4;
   localparam int TMO  = 12;
   localparam int GAPC = 4;
   localparam int MAXO = 3;
   localparam int NEVER = 100000;

   logic           clk;
   logic           reset;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_dir;
   logic [8*N-1:0] req_dato;
   logic [N-1:0]   gnt;
   logic [N-1:0]   done;
   logic [N-1:0]   err;
   logic           iniciar;
   logic [7:0]     dir;
   logic [7:0]     dato;
   logic           final_ack;
   logic           busy;

   rtc_write_arbiter #(
      .N_REQ   (N),
      .TIMEOUT (TMO),
      .GAP     (GAPC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_dir   (req_dir),
      .req_dato  (req_dato),
      .gnt       (gnt),
      .done      (done),
      .err       (err),
      .iniciar   (iniciar),
      .dir       (dir),
      .dato      (dato),
      .final_ack (final_ack),
      .busy      (busy)
   );

   // kind: 0 = done, 1 = err (timeout), 2 = aborted by reset
   typedef struct {
      int         idx;
      logic [7:0] dir;
      logic [7:0] dato;
      int         kind;
      int         run_len;
   } exp_t;

   exp_t sb_q[$];
   int   plan[$];
   int   d_list[$];

   int         n_checks;
   int         n_fail;
   int         cyc;
   int         model_ptr;
   int         cnt[N];
   logic [7:0] odir  [N][MAXO];
   logic [7:0] odato [N][MAXO];
   int         start_cyc;
   bit         lat_armed;

   // monitor state
   logic mon_prev_ini;
   bit   mon_in_txn;
   bit   mon_gap_armed;
   int   mon_run_len;
   int   mon_low_cnt;
   exp_t mon_cur;

   // engine model state
   logic eng_prev;
   int   eng_cnt;
   int   eng_d;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   function automatic logic [N-1:0] onehot(input int i);
      return N'(1) << i;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // ---------------------------------------------------------------- engine
   // Pulses final_ack in the d-th cycle that iniciar is seen high, where d is
   // taken from the plan queue at the start of every transaction.
   initial begin
      final_ack = 1'b0;
      eng_prev  = 1'b0;
      eng_cnt   = 0;
      eng_d     = NEVER;
      forever begin
         @(negedge clk);
         final_ack = 1'b0;
         if (!reset) begin
            eng_prev = 1'b0;
            eng_cnt  = 0;
         end else begin
            if (iniciar && !eng_prev) begin
               eng_d   = (plan.size() > 0) ? plan.pop_front() : NEVER;
               eng_cnt = 0;
            end
            if (iniciar) begin
               eng_cnt++;
               if (eng_cnt == eng_d) final_ack = 1'b1;
            end
            eng_prev = iniciar;
         end
      end
   end

   // ---------------------------------------------------------------- monitor
   initial begin
      mon_prev_ini  = 1'b0;
      mon_in_txn    = 1'b0;
      mon_gap_armed = 1'b0;
      mon_run_len   = 0;
      mon_low_cnt   = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            // Interrupted transactions are expected to vanish without done/err.
            while (sb_q.size() > 0) begin
               check("abort_kind", 32'(sb_q[0].kind), 32'd2);
               void'(sb_q.pop_front());
            end
            mon_in_txn    = 1'b0;
            mon_gap_armed = 1'b0;
            mon_prev_ini  = 1'b0;
            lat_armed     = 1'b0;
         end else begin
            check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            if (iniciar && !mon_prev_ini) begin
               if (sb_q.size() == 0) begin
                  fail_now("unexpected_start");
                  mon_in_txn = 1'b0;
               end else begin
                  mon_cur     = sb_q[0];
                  mon_in_txn  = 1'b1;
                  mon_run_len = 0;
                  check("busy_in_run", 32'(busy), 32'd1);
                  if (mon_gap_armed) check("gap_len", 32'(mon_low_cnt), 32'(GAPC + 2));
                  if (lat_armed) check("req_latency", 32'(cyc - start_cyc), 32'd1);
                  $display("txn start: req %0d dir=%02h dato=%02h", mon_cur.idx, dir, dato);
               end
               mon_gap_armed = 1'b0;
               lat_armed     = 1'b0;
            end
            if (iniciar && mon_in_txn) begin
               mon_run_len++;
               check("run_hold", 32'({gnt, dir, dato}),
                     32'({onehot(mon_cur.idx), mon_cur.dir, mon_cur.dato}));
            end
            if (!iniciar && mon_prev_ini && mon_in_txn && !(|done) && !(|err))
               fail_now("iniciar_drop_without_done_err");
            if ((|done) || (|err)) begin
               if (!mon_in_txn) begin
                  check("stray_done_err", 32'({done, err}), 32'd0);
               end else begin
                  check("done_vec", 32'(done), 32'(mon_cur.kind == 0 ? onehot(mon_cur.idx) : '0));
                  check("err_vec", 32'(err), 32'(mon_cur.kind == 1 ? onehot(mon_cur.idx) : '0));
                  check("run_len", 32'(mon_run_len), 32'(mon_cur.run_len));
                  check("iniciar_low_at_end", 32'(iniciar), 32'd0);
                  $display("txn end: req %0d done=%b err=%b run_len=%0d", mon_cur.idx, done, err, mon_run_len);
                  void'(sb_q.pop_front());
                  mon_in_txn    = 1'b0;
                  mon_gap_armed = (sb_q.size() > 0);
                  mon_low_cnt   = 0;
               end
            end
            if (!iniciar && mon_gap_armed) mon_low_cnt++;
            mon_prev_ini = iniciar;
         end
      end
   end

   // ---------------------------------------------------------------- driver
   task automatic random_data();
      for (int i = 0; i < N; i++) begin
         for (int o = 0; o < MAXO; o++) begin
            odir[i][o]  = 8'($urandom);
            odato[i][o] = 8'($urandom);
         end
      end
   endtask

   task automatic run_scenario(input logic [N-1:0] mask);
      int   rem[N];
      int   served[N];
      int   ptr;
      int   win;
      int   occ;
      int   d;
      int   guard;
      exp_t e;

      // Reference model: plain round-robin over outstanding request counts.
      ptr = model_ptr;
      for (int i = 0; i < N; i++) begin
         rem[i]    = mask[i] ? cnt[i] : 0;
         served[i] = 0;
      end
      while (1) begin
         win = -1;
         for (int k = 1; k <= N; k++) begin
            if (win < 0 && rem[(ptr + k) % N] > 0) win = (ptr + k) % N;
         end
         if (win < 0) break;
         occ       = cnt[win] - rem[win];
         d         = (d_list.size() > 0) ? d_list.pop_front() : int'($urandom_range(1, TMO + 2));
         e.idx     = win;
         e.dir     = odir[win][occ];
         e.dato    = odato[win][occ];
         e.kind    = (d <= TMO) ? 0 : 1;
         e.run_len = (d <= TMO) ? d : TMO;
         sb_q.push_back(e);
         plan.push_back(d);
         rem[win]--;
         ptr = win;
      end
      model_ptr = ptr;

      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         req_dir[8*i +: 8]  = odir[i][0];
         req_dato[8*i +: 8] = odato[i][0];
         req[i]             = mask[i] && (cnt[i] > 0);
      end
      start_cyc = cyc;
      lat_armed = 1'b1;

      guard = 0;
      while (1) begin
         @(negedge clk);
         guard++;
         for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
               // The granted requester's inputs are no longer looked at.
               req_dir[8*i +: 8]  = 8'($urandom);
               req_dato[8*i +: 8] = 8'($urandom);
               if (served[i] == cnt[i] - 1 && $urandom_range(0, 3) == 0) req[i] = 1'b0;
            end
            if (done[i] || err[i]) begin
               served[i]++;
               if (served[i] < cnt[i] && served[i] < MAXO) begin
                  req_dir[8*i +: 8]  = odir[i][served[i]];
                  req_dato[8*i +: 8] = odato[i][served[i]];
               end else begin
                  req[i] = 1'b0;
               end
            end
         end
         if (req == '0 && !busy) break;
         if (guard > 2000) begin
            fail_now("scenario_timeout");
            req = '0;
            sb_q.delete();
            plan.delete();
            break;
         end
      end
      check("scenario_drained", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      #2 reset = 1'b0;
      req = '0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      model_ptr = N - 1;
   endtask

   task automatic reset_mid_run();
      exp_t e;
      int   guard;
      random_data();
      e.idx     = 0;
      e.dir     = odir[0][0];
      e.dato    = odato[0][0];
      e.kind    = 2;
      e.run_len = 0;
      sb_q.push_back(e);
      plan.push_back(NEVER);
      @(negedge clk);
      req_dir[7:0]  = odir[0][0];
      req_dato[7:0] = odato[0][0];
      req           = 4'b0001;
      guard         = 0;
      while (!iniciar && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (!iniciar) fail_now("reset_test_no_start");
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("async_rst_iniciar", 32'(iniciar), 32'd0);
      check("async_rst_gnt", 32'(gnt), 32'd0);
      check("async_rst_dir_dato", 32'({dir, dato}), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_done_err", 32'({done, err}), 32'd0);
      req = '0;
      model_ptr = N - 1;
      repeat (2) @(negedge clk);
      check("rst_no_done_err", 32'({done, err}), 32'd0);
      #2 reset = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b0;
      req       = '0;
      req_dir   = '0;
      req_dato  = '0;
      model_ptr = N - 1;
      lat_armed = 1'b0;
      start_cyc = 0;

      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_iniciar", 32'(iniciar), 32'd0);
      check("rst_dir", 32'(dir), 32'd0);
      check("rst_dato", 32'(dato), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      #2 reset = 1'b1;

      // Two simultaneous requests straight after reset: 0 then 1.
      random_data();
      cnt = '{1, 1, 1, 1};
      run_scenario(4'b0011);

      // Single request with fixed address/data, completion after 6 RUN cycles.
      random_data();
      odir[0][0]  = 8'h81;
      odato[0][0] = 8'h25;
      d_list = '{6};
      run_scenario(4'b0001);

      // All four held, 0 and 1 asking twice: order 0,1,2,3,0,1.
      reset_dut();
      random_data();
      cnt = '{2, 2, 1, 1};
      d_list = '{3, 4, 5, 6, 2, 7};
      run_scenario(4'b1111);

      // Engine never answers: err, then the next requester gets served.
      random_data();
      cnt = '{1, 1, 1, 1};
      d_list = '{TMO + 1};
      run_scenario(4'b0001);
      random_data();
      d_list = '{TMO + 4, 3};
      run_scenario(4'b0011);

      // Completion arriving on the last allowed RUN cycle still counts as done.
      random_data();
      d_list = '{TMO, TMO + 1};
      run_scenario(4'b0110);

      // Reset mid-transaction, then requester 2 wins from the reset pointer.
      reset_mid_run();
      random_data();
      cnt = '{1, 1, 1, 1};
      run_scenario(4'b0100);

      // Random traffic.
      for (int s = 0; s < 30; s++) begin
         random_data();
         for (int i = 0; i < N; i++) cnt[i] = int'($urandom_range(1, 2));
         run_scenario(4'($urandom_range(1, 15)));
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
